// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, opcodes,
// ALU and mux select codes, and the packed control vector.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    I_EXEC   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  localparam logic [1:0] ALU_B_REG    = 2'b00;
  localparam logic [1:0] ALU_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_B_BRANCH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ORI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational map from sequencer state (plus opcode and memory handshake)
// to the datapath control vector.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALU_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        // IR and PC only load in the cycle the fetch actually completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = ALU_B_BRANCH;
        ctrl.alu_op    = ALU_OP_ADD;
        if (!op_legal(op)) begin
          ctrl.illegal_op = 1'b1;
          ctrl.instr_done = 1'b1;
        end
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_IMM;
        ctrl.ext_zero  = 1'b1;
        ctrl.alu_op    = ALU_OP_OR;
      end
      I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALU_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_SRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control sequencer: state register and next-state logic;
// per-state control lines come from mc_ctrl_decode.
module multi_cycle_control
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t cur;
  ctrl_t  dec_ctrl;
  ctrl_t  ctrl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= FETCH;
    end else begin
      case (cur)
        FETCH:    if (mem_ready) cur <= DECODE;
        DECODE: begin
          case (op)
            OP_RTYPE:     cur <= R_EXEC;
            OP_ORI:       cur <= I_EXEC;
            OP_LW, OP_SW: cur <= MEM_ADDR;
            OP_BEQ:       cur <= BRANCH;
            OP_J:         cur <= JUMP;
            default:      cur <= FETCH;
          endcase
        end
        MEM_ADDR: cur <= (op == OP_LW) ? MEM_RD : MEM_WR;
        MEM_RD:   if (mem_ready) cur <= MEM_WB;
        MEM_WR:   if (mem_ready) cur <= FETCH;
        R_EXEC:   cur <= R_WB;
        I_EXEC:   cur <= I_WB;
        default:  cur <= FETCH;
      endcase
    end
  end

  mc_ctrl_decode u_decode (
    .state     (cur),
    .op        (op),
    .mem_ready (mem_ready),
    .ctrl      (dec_ctrl)
  );

  // Reset blanks the FETCH-state requests too, so nothing leaks while rst is high
  assign ctrl = rst ? '0 : dec_ctrl;

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign ext_zero      = ctrl.ext_zero;
  assign alu_op        = ctrl.alu_op;
  assign instr_done    = ctrl.instr_done;
  assign illegal_op    = ctrl.illegal_op;
  assign state         = rst ? 4'd0 : cur;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized scoreboard bench for multi_cycle_control: per-instruction
// expectations are queued at generation time and checked at each instr_done.
module tb_multi_cycle_control;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, ext_zero, instr_done, illegal_op;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;

  multi_cycle_control dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cycles, n_ir, n_pcw, n_pcwc, pcsrc_mask, n_rw, rw_dst, rw_m2r;
    int aluop_mask, n_ext, n_mw, n_dr, n_ill, is_sw;
  } exp_t;

  exp_t       exp_q[$];
  int         acc_q[$];
  logic [5:0] op_q[$];

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_en  = 0;
  bit  directed = 0;

  int cyc, n_ir, n_pcw, n_pcwc, pcsrc_mask, n_rw, rw_dst, rw_m2r;
  int aluop_mask, n_ext, n_mw, n_mw_bad, n_dr, n_ill;

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic int all_outs();
    return int'({pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                 ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                 ext_zero, alu_op, instr_done, illegal_op});
  endfunction

  task automatic clear_acc();
    cyc = 0; n_ir = 0; n_pcw = 0; n_pcwc = 0; pcsrc_mask = 0; n_rw = 0;
    rw_dst = -1; rw_m2r = -1; aluop_mask = 0; n_ext = 0; n_mw = 0;
    n_mw_bad = 0; n_dr = 0; n_ill = 0;
  endtask

  // Reference model: what one instruction should look like, from its class and stalls
  task automatic gen_instr(input logic [5:0] opc, input int fst, input int dst);
    exp_t e;
    e.cycles = 0; e.n_ir = 1; e.n_pcw = 1; e.n_pcwc = 0; e.pcsrc_mask = 1;
    e.n_rw = 0; e.rw_dst = 0; e.rw_m2r = 0; e.aluop_mask = 0; e.n_ext = 0;
    e.n_mw = 0; e.n_dr = 0; e.n_ill = 0; e.is_sw = 0;
    acc_q.push_back(fst);
    case (opc)
      OP_RTYPE: begin e.cycles = 4 + fst; e.n_rw = 1; e.rw_dst = 1; e.aluop_mask = 4; end
      OP_ORI:   begin e.cycles = 4 + fst; e.n_rw = 1; e.aluop_mask = 8; e.n_ext = 1; end
      OP_LW: begin
        e.cycles = 5 + fst + dst; e.n_rw = 1; e.rw_m2r = 1; e.aluop_mask = 1;
        e.n_dr = dst + 1; acc_q.push_back(dst);
      end
      OP_SW: begin
        e.cycles = 4 + fst + dst; e.aluop_mask = 1; e.n_mw = dst + 1; e.is_sw = 1;
        acc_q.push_back(dst);
      end
      OP_BEQ: begin e.cycles = 3 + fst; e.n_pcwc = 1; e.pcsrc_mask = 3; e.aluop_mask = 2; end
      OP_J:   begin e.cycles = 3 + fst; e.n_pcw = 2; e.pcsrc_mask = 5; end
      default: begin e.cycles = 2 + fst; e.n_ill = 1; end
    endcase
    op_q.push_back(opc);
    exp_q.push_back(e);
  endtask

  // Memory model and IR emulation, driven just after each rising edge
  initial begin
    int wait_left;
    bit busy;
    bit fetch_done;
    wait_left = 0; busy = 0; fetch_done = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst && !directed) begin
        if (fetch_done) begin
          op = (op_q.size() != 0) ? op_q.pop_front() : 6'd0;
          fetch_done = 0;
        end
        if (busy && mem_ready) busy = 0;
        if (mem_read || mem_write) begin
          if (!busy) begin
            busy = 1;
            wait_left = (acc_q.size() != 0) ? acc_q.pop_front() : 1000000;
          end else begin
            wait_left--;
          end
          mem_ready = (wait_left == 0);
          if (mem_read && !i_or_d) begin
            fetch_done = mem_ready;
            op = 6'($urandom);
          end
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: accumulate per-instruction activity, compare at instr_done
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      cyc++;
      if (ir_write) n_ir++;
      if (pc_write) n_pcw++;
      if (pc_write_cond) n_pcwc++;
      if (pc_write || pc_write_cond) pcsrc_mask |= (1 << pc_source);
      if (reg_write) begin n_rw++; rw_dst = int'(reg_dst); rw_m2r = int'(mem_to_reg); end
      if (alu_src_a) aluop_mask |= (1 << alu_op);
      if (ext_zero) n_ext++;
      if (mem_write) begin n_mw++; if (!i_or_d) n_mw_bad++; end
      if (mem_read && i_or_d) n_dr++;
      if (illegal_op) n_ill++;
      if (instr_done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cycles", cyc, e.cycles);
          chk("ir_write_count", n_ir, e.n_ir);
          chk("pc_write_count", n_pcw, e.n_pcw);
          chk("pc_write_cond_count", n_pcwc, e.n_pcwc);
          chk("pc_source_set", pcsrc_mask, e.pcsrc_mask);
          chk("reg_write_count", n_rw, e.n_rw);
          if (e.n_rw == 1) begin
            chk("reg_dst", rw_dst, e.rw_dst);
            chk("mem_to_reg", rw_m2r, e.rw_m2r);
          end
          chk("alu_op_set", aluop_mask, e.aluop_mask);
          chk("ext_zero_count", n_ext, e.n_ext);
          chk("mem_write_cycles", n_mw, e.n_mw);
          chk("mem_write_addr_src", n_mw_bad, 0);
          chk("data_read_cycles", n_dr, e.n_dr);
          chk("illegal_count", n_ill, e.n_ill);
          if (e.is_sw == 1) chk("sw_done_with_ready", int'(mem_ready), 1);
        end
        clear_acc();
      end
    end
  end

  initial begin
    logic [5:0] ops [6];
    logic [5:0] o;
    int fst, dst;
    ops[0] = OP_RTYPE; ops[1] = OP_ORI; ops[2] = OP_LW;
    ops[3] = OP_SW;    ops[4] = OP_BEQ; ops[5] = OP_J;
    rst = 1'b1; op = '0; mem_ready = 1'b0;
    clear_acc();

    // Directed plan cases first, then random traffic
    gen_instr(OP_RTYPE, 0, 0);
    gen_instr(OP_LW, 2, 3);
    gen_instr(OP_SW, 0, 4);
    gen_instr(OP_BEQ, 0, 0);
    gen_instr(OP_J, 0, 0);
    gen_instr(OP_ORI, 0, 0);
    gen_instr(6'b111111, 0, 0);
    for (int i = 0; i < 60; i++) begin
      int k;
      k = $urandom_range(0, 6);
      if (k == 6) begin
        do o = 6'($urandom); while (op_legal(o));
      end else begin
        o = ops[k];
      end
      fst = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      dst = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 4) : 0;
      gen_instr(o, fst, dst);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("reset_outputs_zero", all_outs(), 0);
    chk("reset_state", int'(state), int'(FETCH));

    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    // Reset in the middle of a stalled load data access
    #3;
    directed = 1'b1;
    mon_en = 1'b0;
    op = OP_LW;
    mem_ready = 1'b1;
    @(posedge clk); #3;
    mem_ready = 1'b0;
    for (int i = 0; i < 20 && state != MEM_RD; i++) begin
      @(posedge clk); #3;
    end
    chk("reached_mem_rd", int'(state), int'(MEM_RD));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midaccess_reset_state", int'(state), int'(FETCH));
    chk("midaccess_reset_outputs", all_outs(), 0);
    @(posedge clk); #1;
    chk("reset_hold_outputs", all_outs(), 0);
    #3;
    rst = 1'b0;
    #1;
    chk("post_reset_mem_read", int'(mem_read), 1);
    chk("post_reset_i_or_d", int'(i_or_d), 0);
    chk("post_reset_alu_src_b", int'(alu_src_b), 1);
    chk("post_reset_reg_write", int'(reg_write), 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
